fpu_sequencer: RTL and testbench

Issue and stall controller for the multi-cycle floating-point unit in the 2nd-arch core. Sits between the decode stage, which supplies the 5-bit FPU operation code and destination register, and the FPU datapath. Launches each operation, counts its fixed latency, holds the pipeline with `stall` until the result is valid, then emits a one-cycle writeback strobe. Also keeps a free-running count of FPU stall cycles for performance measurement.

---
 rtl/fpu_sequencer.sv | 125 ++++++++++++
 tb/tb_fpu_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_sequencer.sv
// Issue/stall controller for the multi-cycle FPU: launches an operation, counts its
// fixed latency, stalls decode until the result is ready, then strobes writeback.
module fpu_sequencer #(
  parameter int unsigned LAT_ADDSUB = 2,
  parameter int unsigned LAT_MUL    = 2,
  parameter int unsigned LAT_DIV    = 10,
  parameter int unsigned LAT_SQRT   = 8,
  parameter int unsigned LAT_SIMPLE = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        issue,
  input  logic [4:0]  fpu_ctrl,
  input  logic [4:0]  dest,
  input  logic        flush,
  output logic        stall,
  output logic        fpu_start,
  output logic [4:0]  fpu_op,
  output logic        wb_valid,
  output logic [4:0]  wb_dest,
  output logic        busy,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_ADDSUB = 4'(LAT_ADDSUB - 1);
  localparam logic [3:0] CNT_MUL    = 4'(LAT_MUL - 1);
  localparam logic [3:0] CNT_DIV    = 4'(LAT_DIV - 1);
  localparam logic [3:0] CNT_SQRT   = 4'(LAT_SQRT - 1);
  localparam logic [3:0] CNT_SIMPLE = 4'(LAT_SIMPLE - 1);

  state_t     state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [4:0] op_d, dest_d;
  logic       start_d;
  logic       code_valid;
  logic [3:0] cnt_init;

  // Decode the operation code into validity and the initial latency count (LAT-1).
  always_comb begin
    code_valid = 1'b1;
    cnt_init   = CNT_SIMPLE;
    case (fpu_ctrl)
      5'b00001, 5'b00011: cnt_init = CNT_ADDSUB;
      5'b00101:           cnt_init = CNT_MUL;
      5'b00111:           cnt_init = CNT_DIV;
      5'b01101:           cnt_init = CNT_SQRT;
      5'b01001, 5'b01011, 5'b01111,
      5'b10001, 5'b10011, 5'b10101: cnt_init = CNT_SIMPLE;
      default:            code_valid = 1'b0;
    endcase
  end

  // Next-state logic; stall is deliberately independent of flush.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    op_d    = fpu_op;
    dest_d  = wb_dest;
    start_d = 1'b0;
    stall   = 1'b0;
    case (state)
      IDLE: begin
        stall = issue && code_valid;
        if (!flush && issue && code_valid) begin
          state_d = RUN;
          cnt_d   = cnt_init;
          op_d    = fpu_ctrl;
          dest_d  = dest;
          start_d = 1'b1;
        end
      end
      RUN: begin
        stall = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else if (cnt == 4'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      fpu_op    <= 5'd0;
      wb_dest   <= 5'd0;
      fpu_start <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      fpu_op    <= op_d;
      wb_dest   <= dest_d;
      fpu_start <= start_d;
    end
  end

  // Free-running performance counter; wraps naturally and clears only on reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cycles <= 32'd0;
    end else if (stall) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

  assign busy     = (state != IDLE);
  assign wb_valid = (state == DONE) && !flush;

endmodule

// File: tb/tb_fpu_sequencer.sv
// Directed bench for fpu_sequencer: a vector table of single issues plus
// hand-written sequences for flush, back-to-back, counter wrap and reset.
module tb_fpu_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        issue = 1'b0;
  logic [4:0]  fpu_ctrl = 5'd0;
  logic [4:0]  dest = 5'd0;
  logic        flush = 1'b0;
  logic        stall;
  logic        fpu_start;
  logic [4:0]  fpu_op;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic        busy;
  logic [31:0] stall_cycles;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_sc = 32'd0;

  fpu_sequencer dut (
    .clk(clk), .rstn(rstn), .issue(issue), .fpu_ctrl(fpu_ctrl), .dest(dest),
    .flush(flush), .stall(stall), .fpu_start(fpu_start), .fpu_op(fpu_op),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .busy(busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iss;
    logic [4:0] ctrl;
    logic [4:0] dst;
    logic       fl;
    logic       exp_stall;
    int         exp_lat;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic i, input logic [4:0] c,
                               input logic [4:0] d, input logic f);
    issue = i;
    fpu_ctrl = c;
    dest = d;
    flush = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int seen;

    vecs[0]  = '{1'b1, 5'b00001, 5'd7,  1'b0, 1'b1, 2};
    vecs[1]  = '{1'b1, 5'b00011, 5'd3,  1'b0, 1'b1, 2};
    vecs[2]  = '{1'b1, 5'b00101, 5'd12, 1'b0, 1'b1, 2};
    vecs[3]  = '{1'b1, 5'b00111, 5'd1,  1'b0, 1'b1, 10};
    vecs[4]  = '{1'b1, 5'b01001, 5'd31, 1'b0, 1'b1, 1};
    vecs[5]  = '{1'b1, 5'b01011, 5'd2,  1'b0, 1'b1, 1};
    vecs[6]  = '{1'b1, 5'b01101, 5'd9,  1'b0, 1'b1, 8};
    vecs[7]  = '{1'b1, 5'b01111, 5'd20, 1'b0, 1'b1, 1};
    vecs[8]  = '{1'b1, 5'b10001, 5'd17, 1'b0, 1'b1, 1};
    vecs[9]  = '{1'b1, 5'b10011, 5'd5,  1'b0, 1'b1, 1};
    vecs[10] = '{1'b1, 5'b10101, 5'd4,  1'b0, 1'b1, 1};
    vecs[11] = '{1'b1, 5'b00000, 5'd6,  1'b0, 1'b0, 0};
    vecs[12] = '{1'b1, 5'b00010, 5'd6,  1'b0, 1'b0, 0};
    vecs[13] = '{1'b1, 5'b11111, 5'd6,  1'b0, 1'b0, 0};
    vecs[14] = '{1'b1, 5'b10111, 5'd6,  1'b0, 1'b0, 0};
    vecs[15] = '{1'b0, 5'b00001, 5'd6,  1'b0, 1'b0, 0};
    vecs[16] = '{1'b1, 5'b00101, 5'd6,  1'b1, 1'b1, 0};
    vecs[17] = '{1'b0, 5'b00111, 5'd6,  1'b1, 1'b0, 0};

    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset stall", {31'd0, stall}, 32'd0);
    checkOutput("reset fpu_start", {31'd0, fpu_start}, 32'd0);
    checkOutput("reset fpu_op", {27'd0, fpu_op}, 32'd0);
    checkOutput("reset wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("reset wb_dest", {27'd0, wb_dest}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset stall_cycles", stall_cycles, 32'd0);
    rstn = 1'b1;
    tick();

    // Table-driven single issues, issue held until the DONE cycle.
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].iss, vecs[i].ctrl, vecs[i].dst, vecs[i].fl);
      #1;
      checkOutput($sformatf("vec%0d stall", i), {31'd0, stall}, {31'd0, vecs[i].exp_stall});
      tick();
      checkOutput($sformatf("vec%0d fpu_start", i), {31'd0, fpu_start},
                  {31'd0, vecs[i].exp_lat != 0});
      checkOutput($sformatf("vec%0d busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_lat != 0});
      if (vecs[i].exp_lat != 0) begin
        checkOutput($sformatf("vec%0d fpu_op", i), {27'd0, fpu_op}, {27'd0, vecs[i].ctrl});
        n = 1;
        while (!wb_valid && n < 20) begin
          tick();
          n++;
        end
        checkOutput($sformatf("vec%0d wb cycle", i), n, vecs[i].exp_lat + 1);
        checkOutput($sformatf("vec%0d wb_valid", i), {31'd0, wb_valid}, 32'd1);
        checkOutput($sformatf("vec%0d wb_dest", i), {27'd0, wb_dest}, {27'd0, vecs[i].dst});
        checkOutput($sformatf("vec%0d done stall", i), {31'd0, stall}, 32'd0);
        exp_sc = exp_sc + 32'(vecs[i].exp_lat + 1);
      end else begin
        exp_sc = exp_sc + {31'd0, vecs[i].exp_stall};
      end
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0);
      tick();
      checkOutput($sformatf("vec%0d idle busy", i), {31'd0, busy}, 32'd0);
      checkOutput($sformatf("vec%0d idle wb_valid", i), {31'd0, wb_valid}, 32'd0);
      checkOutput($sformatf("vec%0d stall_cycles", i), stall_cycles, exp_sc);
    end

    // Flush in the DONE cycle suppresses the writeback strobe.
    applyStimulus(1'b1, 5'b01001, 5'd8, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    checkOutput("fdone wb before flush", {31'd0, wb_valid}, 32'd1);
    flush = 1'b1;
    #1;
    checkOutput("fdone wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("fdone busy", {31'd0, busy}, 32'd1);
    tick();
    flush = 1'b0;
    checkOutput("fdone idle busy", {31'd0, busy}, 32'd0);
    checkOutput("fdone idle wb", {31'd0, wb_valid}, 32'd0);
    exp_sc = exp_sc + 32'd2;

    // Flush during fdiv at T+4, then an fmul at T+6 writing back at T+9.
    applyStimulus(1'b1, 5'b00111, 5'd2, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
    tick();
    flush = 1'b1;
    #1;
    checkOutput("fdiv flush stall", {31'd0, stall}, 32'd1);
    tick();
    flush = 1'b0;
    checkOutput("fdiv T+5 busy", {31'd0, busy}, 32'd0);
    checkOutput("fdiv T+5 stall", {31'd0, stall}, 32'd0);
    checkOutput("fdiv T+5 wb", {31'd0, wb_valid}, 32'd0);
    exp_sc = exp_sc + 32'd5;
    tick();
    checkOutput("fdiv T+6 wb", {31'd0, wb_valid}, 32'd0);
    applyStimulus(1'b1, 5'b00101, 5'd6, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0);
    checkOutput("fmul T+7 start", {31'd0, fpu_start}, 32'd1);
    tick();
    checkOutput("fmul T+8 wb", {31'd0, wb_valid}, 32'd0);
    tick();
    checkOutput("fmul T+9 wb", {31'd0, wb_valid}, 32'd1);
    checkOutput("fmul T+9 dest", {27'd0, wb_dest}, 32'd6);
    exp_sc = exp_sc + 32'd3;
    tick();
    checkOutput("flush seq stall_cycles", stall_cycles, exp_sc);

    // fdiv then fsqrt back-to-back with issue held throughout.
    applyStimulus(1'b1, 5'b00111, 5'd10, 1'b0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!wb_valid && n < 30);
    checkOutput("b2b fdiv wb cycle", n, 32'd11);
    checkOutput("b2b fdiv dest", {27'd0, wb_dest}, 32'd10);
    fpu_ctrl = 5'b01101;
    dest = 5'd11;
    do begin
      tick();
      n++;
    end while (!wb_valid && n < 40);
    checkOutput("b2b fsqrt wb cycle", n, 32'd21);
    checkOutput("b2b fsqrt dest", {27'd0, wb_dest}, 32'd11);
    checkOutput("b2b fsqrt op", {27'd0, fpu_op}, 32'b01101);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    exp_sc = exp_sc + 32'd20;
    checkOutput("b2b stall_cycles", stall_cycles, exp_sc);

    // Counter wrap from 0xFFFFFFFE over a 3-stall-cycle fmul.
    force dut.stall_cycles = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cycles;
    applyStimulus(1'b1, 5'b00101, 5'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0);
    checkOutput("wrap T+1", stall_cycles, 32'hFFFF_FFFF);
    tick();
    checkOutput("wrap T+2", stall_cycles, 32'd0);
    tick();
    tick();
    checkOutput("wrap final", stall_cycles, 32'd1);

    // Asynchronous reset in the middle of an fdiv.
    applyStimulus(1'b1, 5'b00111, 5'd15, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("midrst busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst fpu_op", {27'd0, fpu_op}, 32'd0);
    checkOutput("midrst wb_dest", {27'd0, wb_dest}, 32'd0);
    checkOutput("midrst stall", {31'd0, stall}, 32'd0);
    checkOutput("midrst stall_cycles", stall_cycles, 32'd0);
    tick();
    rstn = 1'b1;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (wb_valid || busy || fpu_start) seen++;
    end
    checkOutput("midrst no activity", seen, 32'd0);
    checkOutput("midrst counter after", stall_cycles, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
